// File: rtl/adc_capture_sequencer_if.sv
// AXI-Stream beat channel between the ADC capture sequencer and the DMA stream input.
// One 64-bit beat carries a packed 4-channel sample; the master drives data/valid/last and the slave drives ready.
interface adc_capture_sequencer_if;
   logic [63:0] M_TDATA;
   logic        M_TVALID;
   logic        M_TREADY;
   logic        M_TLAST;

   modport master (
      output M_TDATA,
      output M_TVALID,
      output M_TLAST,
      input  M_TREADY
   );

   modport slave (
      input  M_TDATA,
      input  M_TVALID,
      input  M_TLAST,
      output M_TREADY
   );
endinterface

// File: rtl/adc_capture_sequencer.sv
// One capture run of the quad ADC stream: discard settling samples, decimate,
// pack kept samples into 64-bit AXI-Stream beats, and end the run with TLAST.
module adc_capture_sequencer #(
   parameter bit          SIGN_EXTEND = 1'b1,
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                   AXI_CLK,
   input  logic                   RESET_N,
   input  logic                   START,
   input  logic                   ABORT,
   input  logic [COUNT_WIDTH-1:0] SAMPLE_COUNT,
   input  logic [15:0]            SKIP_COUNT,
   input  logic [7:0]             DECIMATION,
   input  logic                   AXI_DATA_VALID,
   input  logic [13:0]            AXI_CH_1_DATA,
   input  logic [13:0]            AXI_CH_2_DATA,
   input  logic [13:0]            AXI_CH_3_DATA,
   input  logic [13:0]            AXI_CH_4_DATA,
   adc_capture_sequencer_if.master M_AXIS,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   OVERFLOW,
   output logic [COUNT_WIDTH-1:0] SAMPLES_WRITTEN
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SKIP,
      ST_CAPTURE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t                 state;
   logic [COUNT_WIDTH-1:0] cfg_count;
   logic [15:0]            cfg_skip;
   logic [7:0]             cfg_dec;
   logic [15:0]            skip_cnt;
   logic [7:0]             dec_cnt;
   logic [COUNT_WIDTH-1:0] kept_cnt;
   logic [63:0]            tdata_q;
   logic                   tvalid_q;
   logic                   tlast_q;
   logic                   overflow_q;
   logic [COUNT_WIDTH-1:0] written_q;

   logic [63:0]            packed_sample;
   logic                   handshake;
   logic                   beat_is_last;
   logic                   keep_sample;
   logic                   can_load;

   function automatic logic [15:0] ext14(input logic [13:0] x);
      ext14 = SIGN_EXTEND ? {{2{x[13]}}, x} : {2'b00, x};
   endfunction

   always_comb begin
      packed_sample = {ext14(AXI_CH_4_DATA), ext14(AXI_CH_3_DATA),
                       ext14(AXI_CH_2_DATA), ext14(AXI_CH_1_DATA)};
      handshake     = tvalid_q && M_AXIS.M_TREADY;
      beat_is_last  = (kept_cnt == (cfg_count - COUNT_WIDTH'(1)));
      keep_sample   = (dec_cnt == 8'd0);
      can_load      = !tvalid_q || M_AXIS.M_TREADY;
   end

   always_ff @(posedge AXI_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= ST_IDLE;
         cfg_count  <= '0;
         cfg_skip   <= '0;
         cfg_dec    <= '0;
         skip_cnt   <= '0;
         dec_cnt    <= '0;
         kept_cnt   <= '0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         overflow_q <= 1'b0;
         written_q  <= '0;
      end else begin
         // A beat accepted downstream in the same cycle as ABORT was really transferred, so it still counts.
         if (handshake) begin
            written_q <= written_q + COUNT_WIDTH'(1);
         end

         if (ABORT && (state != ST_IDLE)) begin
            state    <= ST_IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (START && !ABORT) begin
                     cfg_count  <= SAMPLE_COUNT;
                     cfg_skip   <= SKIP_COUNT;
                     cfg_dec    <= DECIMATION;
                     skip_cnt   <= '0;
                     dec_cnt    <= '0;
                     kept_cnt   <= '0;
                     overflow_q <= 1'b0;
                     written_q  <= '0;
                     if (SAMPLE_COUNT == '0) begin
                        state <= ST_DONE;
                     end else if (SKIP_COUNT != '0) begin
                        state <= ST_SKIP;
                     end else begin
                        state <= ST_CAPTURE;
                     end
                  end
               end

               ST_SKIP: begin
                  if (AXI_DATA_VALID) begin
                     skip_cnt <= skip_cnt + 16'd1;
                     if ((skip_cnt + 16'd1) == cfg_skip) begin
                        state <= ST_CAPTURE;
                     end
                  end
               end

               ST_CAPTURE: begin
                  if (handshake) begin
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                  end
                  if (AXI_DATA_VALID) begin
                     dec_cnt <= keep_sample ? cfg_dec : (dec_cnt - 8'd1);
                     if (keep_sample) begin
                        if (can_load) begin
                           tdata_q  <= packed_sample;
                           tvalid_q <= 1'b1;
                           tlast_q  <= beat_is_last;
                           kept_cnt <= kept_cnt + COUNT_WIDTH'(1);
                           if (beat_is_last) begin
                              state <= ST_DRAIN;
                           end
                        end else begin
                           overflow_q <= 1'b1;
                        end
                     end
                  end
               end

               ST_DRAIN: begin
                  if (handshake) begin
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     state    <= ST_DONE;
                  end
               end

               ST_DONE: begin
                  state <= ST_IDLE;
               end

               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign M_AXIS.M_TDATA  = tdata_q;
   assign M_AXIS.M_TVALID = tvalid_q;
   assign M_AXIS.M_TLAST  = tlast_q;
   assign BUSY            = (state != ST_IDLE);
   assign DONE            = (state == ST_DONE);
   assign OVERFLOW        = overflow_q;
   assign SAMPLES_WRITTEN = written_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: skip, decimation, packing, stall/overflow,
// zero-length run, abort, and asynchronous reset mid-run.
module tb_adc_capture_sequencer;
   localparam int unsigned CW = 32;

   logic          AXI_CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          START = 1'b0;
   logic          ABORT = 1'b0;
   logic [CW-1:0] SAMPLE_COUNT = '0;
   logic [15:0]   SKIP_COUNT = '0;
   logic [7:0]    DECIMATION = '0;
   logic          AXI_DATA_VALID = 1'b0;
   logic [13:0]   AXI_CH_1_DATA = '0;
   logic [13:0]   AXI_CH_2_DATA = '0;
   logic [13:0]   AXI_CH_3_DATA = '0;
   logic [13:0]   AXI_CH_4_DATA = '0;
   logic          BUSY, DONE, OVERFLOW;
   logic [CW-1:0] SAMPLES_WRITTEN;
   logic          z_busy, z_done, z_overflow;
   logic [CW-1:0] z_written;

   int checks = 0;
   int failures = 0;

   adc_capture_sequencer_if m_axis ();
   adc_capture_sequencer_if m_axis_z ();
   assign m_axis_z.M_TREADY = m_axis.M_TREADY;

   adc_capture_sequencer #(.SIGN_EXTEND(1'b1), .COUNT_WIDTH(CW)) dut (
      .AXI_CLK(AXI_CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
      .SAMPLE_COUNT(SAMPLE_COUNT), .SKIP_COUNT(SKIP_COUNT), .DECIMATION(DECIMATION),
      .AXI_DATA_VALID(AXI_DATA_VALID),
      .AXI_CH_1_DATA(AXI_CH_1_DATA), .AXI_CH_2_DATA(AXI_CH_2_DATA),
      .AXI_CH_3_DATA(AXI_CH_3_DATA), .AXI_CH_4_DATA(AXI_CH_4_DATA),
      .M_AXIS(m_axis.master), .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW),
      .SAMPLES_WRITTEN(SAMPLES_WRITTEN)
   );

   adc_capture_sequencer #(.SIGN_EXTEND(1'b0), .COUNT_WIDTH(CW)) dut_z (
      .AXI_CLK(AXI_CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
      .SAMPLE_COUNT(SAMPLE_COUNT), .SKIP_COUNT(SKIP_COUNT), .DECIMATION(DECIMATION),
      .AXI_DATA_VALID(AXI_DATA_VALID),
      .AXI_CH_1_DATA(AXI_CH_1_DATA), .AXI_CH_2_DATA(AXI_CH_2_DATA),
      .AXI_CH_3_DATA(AXI_CH_3_DATA), .AXI_CH_4_DATA(AXI_CH_4_DATA),
      .M_AXIS(m_axis_z.master), .BUSY(z_busy), .DONE(z_done), .OVERFLOW(z_overflow),
      .SAMPLES_WRITTEN(z_written)
   );

   always #5 AXI_CLK = ~AXI_CLK;

   task automatic tick();
      @(posedge AXI_CLK);
      #1;
   endtask

   task automatic strobe(input int c1, input int c2, input int c3, input int c4);
      AXI_DATA_VALID = 1'b1;
      AXI_CH_1_DATA  = 14'(c1);
      AXI_CH_2_DATA  = 14'(c2);
      AXI_CH_3_DATA  = 14'(c3);
      AXI_CH_4_DATA  = 14'(c4);
   endtask

   task automatic start_run(input int count, input int skip, input int dec);
      SAMPLE_COUNT = CW'(count);
      SKIP_COUNT   = 16'(skip);
      DECIMATION   = 8'(dec);
      START        = 1'b1;
      tick();
      START        = 1'b0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      m_axis.M_TREADY = 1'b0;
      tick();
      tick();
      checks++; if (m_axis.M_TVALID !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b want=0", m_axis.M_TVALID); end
      checks++; if (m_axis.M_TLAST !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b want=0", m_axis.M_TLAST); end
      checks++; if (m_axis.M_TDATA !== 64'h0) begin failures++; $display("FAIL reset_tdata got=%h want=0", m_axis.M_TDATA); end
      checks++; if ({BUSY, DONE, OVERFLOW} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {BUSY, DONE, OVERFLOW}); end
      checks++; if (SAMPLES_WRITTEN !== '0) begin failures++; $display("FAIL reset_written got=%0d want=0", SAMPLES_WRITTEN); end
      RESET_N = 1'b1;
      tick();
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b want=0", BUSY); end
   endtask

   task automatic test_skip_capture();
      logic [63:0] exp;
      m_axis.M_TREADY = 1'b1;
      start_run(4, 2, 0);
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL p1_busy got=%b want=1", BUSY); end
      for (int i = 1; i <= 6; i++) begin
         strobe(i, i + 100, i + 200, i + 300);
         tick();
         if (i >= 3) begin
            exp = {16'(i + 300), 16'(i + 200), 16'(i + 100), 16'(i)};
            checks++; if (m_axis.M_TVALID !== 1'b1) begin failures++; $display("FAIL p1_tvalid s=%0d got=%b want=1", i, m_axis.M_TVALID); end
            checks++; if (m_axis.M_TDATA !== exp) begin failures++; $display("FAIL p1_tdata s=%0d got=%h want=%h", i, m_axis.M_TDATA, exp); end
            checks++; if (m_axis.M_TLAST !== (i == 6)) begin failures++; $display("FAIL p1_tlast s=%0d got=%b want=%b", i, m_axis.M_TLAST, (i == 6)); end
            checks++; if (SAMPLES_WRITTEN !== CW'(i - 3)) begin failures++; $display("FAIL p1_written s=%0d got=%0d want=%0d", i, SAMPLES_WRITTEN, i - 3); end
         end else begin
            checks++; if (m_axis.M_TVALID !== 1'b0) begin failures++; $display("FAIL p1_skip_tvalid s=%0d got=%b want=0", i, m_axis.M_TVALID); end
         end
      end
      AXI_DATA_VALID = 1'b0;
      tick();
      checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL p1_done got=%b want=1", DONE); end
      checks++; if (SAMPLES_WRITTEN !== CW'(4)) begin failures++; $display("FAIL p1_written_final got=%0d want=4", SAMPLES_WRITTEN); end
      checks++; if (m_axis.M_TVALID !== 1'b0) begin failures++; $display("FAIL p1_tvalid_after got=%b want=0", m_axis.M_TVALID); end
      checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL p1_overflow got=%b want=0", OVERFLOW); end
      tick();
      checks++; if ({DONE, BUSY} !== 2'b00) begin failures++; $display("FAIL p1_idle got=%b want=00", {DONE, BUSY}); end
   endtask

   task automatic test_decimation();
      logic exp_valid;
      m_axis.M_TREADY = 1'b1;
      start_run(3, 0, 2);
      for (int i = 0; i <= 8; i++) begin
         strobe(i, 0, 0, 0);
         tick();
         exp_valid = (i <= 6) && (i % 3 == 0);
         checks++; if (m_axis.M_TVALID !== exp_valid) begin failures++; $display("FAIL p2_tvalid s=%0d got=%b want=%b", i, m_axis.M_TVALID, exp_valid); end
         if (exp_valid) begin
            checks++; if (m_axis.M_TDATA[15:0] !== 16'(i)) begin failures++; $display("FAIL p2_ch1 s=%0d got=%h want=%h", i, m_axis.M_TDATA[15:0], 16'(i)); end
            checks++; if (m_axis.M_TLAST !== (i == 6)) begin failures++; $display("FAIL p2_tlast s=%0d got=%b want=%b", i, m_axis.M_TLAST, (i == 6)); end
         end
         if (i == 7) begin
            checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL p2_done got=%b want=1", DONE); end
            checks++; if (SAMPLES_WRITTEN !== CW'(3)) begin failures++; $display("FAIL p2_written got=%0d want=3", SAMPLES_WRITTEN); end
         end
      end
      AXI_DATA_VALID = 1'b0;
      tick();
   endtask

   task automatic test_sign_pack();
      m_axis.M_TREADY = 1'b1;
      start_run(1, 0, 0);
      strobe(14'h2000, 14'h1FFF, 0, 14'h3FFF);
      tick();
      AXI_DATA_VALID = 1'b0;
      checks++; if (m_axis.M_TDATA !== 64'hFFFF_0000_1FFF_E000) begin failures++; $display("FAIL p3_sign got=%h want=ffff00001fffe000", m_axis.M_TDATA); end
      checks++; if (m_axis_z.M_TDATA !== 64'h3FFF_0000_1FFF_2000) begin failures++; $display("FAIL p3_zero got=%h want=3fff00001fff2000", m_axis_z.M_TDATA); end
      checks++; if (m_axis.M_TLAST !== 1'b1) begin failures++; $display("FAIL p3_tlast got=%b want=1", m_axis.M_TLAST); end
      tick();
      tick();
   endtask

   task automatic test_overflow();
      m_axis.M_TREADY = 1'b0;
      start_run(2, 0, 0);
      for (int i = 10; i <= 12; i++) begin
         strobe(i, 0, 0, 0);
         tick();
         checks++; if (m_axis.M_TDATA[15:0] !== 16'd10) begin failures++; $display("FAIL p4_hold s=%0d got=%h want=000a", i, m_axis.M_TDATA[15:0]); end
         checks++; if (m_axis.M_TVALID !== 1'b1) begin failures++; $display("FAIL p4_tvalid s=%0d got=%b want=1", i, m_axis.M_TVALID); end
         checks++; if (OVERFLOW !== (i > 10)) begin failures++; $display("FAIL p4_overflow s=%0d got=%b want=%b", i, OVERFLOW, (i > 10)); end
      end
      AXI_DATA_VALID = 1'b0;
      m_axis.M_TREADY = 1'b1;
      tick();
      checks++; if (m_axis.M_TVALID !== 1'b0) begin failures++; $display("FAIL p4_drained got=%b want=0", m_axis.M_TVALID); end
      checks++; if (SAMPLES_WRITTEN !== CW'(1)) begin failures++; $display("FAIL p4_written1 got=%0d want=1", SAMPLES_WRITTEN); end
      strobe(13, 0, 0, 0);
      tick();
      checks++; if ({m_axis.M_TVALID, m_axis.M_TLAST} !== 2'b11) begin failures++; $display("FAIL p4_last_beat got=%b want=11", {m_axis.M_TVALID, m_axis.M_TLAST}); end
      checks++; if (m_axis.M_TDATA[15:0] !== 16'd13) begin failures++; $display("FAIL p4_last_data got=%h want=000d", m_axis.M_TDATA[15:0]); end
      strobe(14, 0, 0, 0);
      tick();
      AXI_DATA_VALID = 1'b0;
      checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL p4_done got=%b want=1", DONE); end
      checks++; if (SAMPLES_WRITTEN !== CW'(2)) begin failures++; $display("FAIL p4_written2 got=%0d want=2", SAMPLES_WRITTEN); end
      tick();
      checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL p4_sticky got=%b want=1", OVERFLOW); end
   endtask

   task automatic test_zero_count();
      start_run(0, 0, 0);
      checks++; if ({BUSY, DONE, m_axis.M_TVALID} !== 3'b110) begin failures++; $display("FAIL p5_done got=%b want=110", {BUSY, DONE, m_axis.M_TVALID}); end
      tick();
      checks++; if ({BUSY, DONE, m_axis.M_TVALID} !== 3'b000) begin failures++; $display("FAIL p5_idle got=%b want=000", {BUSY, DONE, m_axis.M_TVALID}); end
   endtask

   task automatic test_abort();
      m_axis.M_TREADY = 1'b0;
      start_run(5, 0, 0);
      strobe(20, 0, 0, 0);
      tick();
      m_axis.M_TREADY = 1'b1;
      strobe(21, 0, 0, 0);
      tick();
      m_axis.M_TREADY = 1'b0;
      strobe(22, 0, 0, 0);
      tick();
      checks++; if (OVERFLOW !== 1'b1 || m_axis.M_TDATA[15:0] !== 16'd21) begin failures++; $display("FAIL p6_stall got=%b/%h want=1/0015", OVERFLOW, m_axis.M_TDATA[15:0]); end
      ABORT = 1'b1;
      START = 1'b1;
      strobe(23, 0, 0, 0);
      tick();
      ABORT = 1'b0;
      START = 1'b0;
      AXI_DATA_VALID = 1'b0;
      checks++; if ({m_axis.M_TVALID, m_axis.M_TLAST} !== 2'b00) begin failures++; $display("FAIL p6_abort_tvalid got=%b want=00", {m_axis.M_TVALID, m_axis.M_TLAST}); end
      checks++; if ({BUSY, DONE} !== 2'b00) begin failures++; $display("FAIL p6_abort_state got=%b want=00", {BUSY, DONE}); end
      checks++; if (SAMPLES_WRITTEN !== CW'(1)) begin failures++; $display("FAIL p6_written_hold got=%0d want=1", SAMPLES_WRITTEN); end
      tick();
      checks++; if ({BUSY, DONE, OVERFLOW} !== 3'b001) begin failures++; $display("FAIL p6_after got=%b want=001", {BUSY, DONE, OVERFLOW}); end
      m_axis.M_TREADY = 1'b1;
      start_run(1, 0, 0);
      checks++; if ({BUSY, OVERFLOW} !== 2'b10 || SAMPLES_WRITTEN !== '0) begin failures++; $display("FAIL p6_restart got=%b/%0d want=10/0", {BUSY, OVERFLOW}, SAMPLES_WRITTEN); end
      strobe(24, 0, 0, 0);
      tick();
      AXI_DATA_VALID = 1'b0;
      tick();
      checks++; if (DONE !== 1'b1 || SAMPLES_WRITTEN !== CW'(1)) begin failures++; $display("FAIL p6_rerun got=%b/%0d want=1/1", DONE, SAMPLES_WRITTEN); end
      tick();
   endtask

   task automatic test_reset_mid_run();
      m_axis.M_TREADY = 1'b0;
      start_run(3, 0, 0);
      strobe(30, 0, 0, 0);
      tick();
      AXI_DATA_VALID = 1'b0;
      checks++; if (m_axis.M_TVALID !== 1'b1) begin failures++; $display("FAIL rst_pre got=%b want=1", m_axis.M_TVALID); end
      #2;
      RESET_N = 1'b0;
      #1;
      checks++; if ({m_axis.M_TVALID, BUSY} !== 2'b00) begin failures++; $display("FAIL rst_async got=%b want=00", {m_axis.M_TVALID, BUSY}); end
      tick();
      RESET_N = 1'b1;
      tick();
      checks++; if (m_axis.M_TDATA !== 64'h0 || SAMPLES_WRITTEN !== '0) begin failures++; $display("FAIL rst_values got=%h/%0d want=0/0", m_axis.M_TDATA, SAMPLES_WRITTEN); end
   endtask

   initial begin
      test_reset();
      test_skip_capture();
      test_decimation();
      test_sign_pack();
      test_overflow();
      test_zero_count();
      test_abort();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
- Controls one capture run of the quad ADC sample stream after the stream has crossed into the AXI clock domain.
- On START, discards a programmable number of settling samples, then decimates the stream.
- Packs each kept 4-channel sample into one 64-bit AXI-Stream beat and ends the run with TLAST after exactly SAMPLE_COUNT beats.
- Sits between the quad ADC clock-domain crossing and the DMA stream input; register-file fields drive START, ABORT and the configuration inputs.

Parameters:
SIGN_EXTEND, 1, 1 = each 14-bit channel sign-extended to 16 bits; 0 = zero-extended
COUNT_WIDTH, 32, width of SAMPLE_COUNT and SAMPLES_WRITTEN

Ports:
AXI_CLK  input  1  sole clock
RESET_N  input  1  asynchronous active-low reset
START  input  1  single-cycle pulse; begins a run when idle
ABORT  input  1  single-cycle pulse; terminates a run
SAMPLE_COUNT  input  COUNT_WIDTH  beats per run; latched on START
SKIP_COUNT  input  16  settling samples to discard; latched on START
DECIMATION  input  8  keep 1 of every DECIMATION+1 samples; latched on START
AXI_DATA_VALID  input  1  one-cycle strobe; sample present on the channel inputs
AXI_CH_1_DATA..AXI_CH_4_DATA  input  14 each  channel samples
M_TDATA  output  64  {ch4,ch3,ch2,ch1}, 16 bits per channel, ch1 in [15:0]
M_TVALID  output  1  stream valid
M_TREADY  input  1  stream ready
M_TLAST  output  1  high on the final beat of a run
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle pulse when a run completes normally
OVERFLOW  output  1  sticky flag; a kept sample was dropped because the output was stalled
SAMPLES_WRITTEN  output  COUNT_WIDTH  number of beats handshaked in the current or most recent run

Behaviour:
- Reset values: every output is 0; state is IDLE; all counters are 0.
- States: IDLE, SKIP, CAPTURE, DRAIN, DONE.
- IDLE:
  - START latches the config, clears OVERFLOW and SAMPLES_WRITTEN, and zeroes the skip, decimation and kept counters.
  - Next state is DONE if SAMPLE_COUNT=0 (no beats are emitted), else SKIP if SKIP_COUNT>0, else CAPTURE.
  - A sample strobe in the START cycle is ignored.
- SKIP:
  - Each AXI_DATA_VALID increments the skip counter.
  - On the strobe that makes the counter equal SKIP_COUNT, go to CAPTURE. That sample is discarded.
- CAPTURE, decimation:
  - Each strobe is kept only if the decimation counter is 0. The counter then becomes DECIMATION when it was 0, otherwise counter-1.
  - The first sample after SKIP is therefore always kept.
- CAPTURE, output holding register:
  - A kept sample loads the register when M_TVALID=0 or M_TREADY=1 (back-to-back beats are allowed).
  - Latency: strobe at cycle n gives M_TVALID at n+1.
  - Otherwise the sample is dropped and OVERFLOW is set. Dropped samples do not count toward SAMPLE_COUNT.
- Beat count:
  - Loaded beats increment the kept counter.
  - The beat with kept index SAMPLE_COUNT-1 carries M_TLAST=1; on loading it, go to DRAIN. Later strobes are ignored.
- AXI-Stream rule: M_TDATA and M_TLAST are held stable while M_TVALID=1 and M_TREADY=0.
- SAMPLES_WRITTEN increments on every M_TVALID&&M_TREADY cycle.
- DRAIN: on the handshake of the TLAST beat, go to DONE.
- DONE: DONE=1 for one cycle, then IDLE. BUSY is high in DONE.
- ABORT:
  - In any non-IDLE state, the next state is IDLE.
  - M_TVALID and M_TLAST clear immediately; any held beat is discarded and no DONE pulse is produced.
  - ABORT has priority over START and over a simultaneous sample strobe.
- START while BUSY is ignored, and the config is not relatched.
- OVERFLOW and SAMPLES_WRITTEN hold their values after a run and clear only on the next accepted START or on reset.
- Packing: 14-bit channel data is extended to 16 bits according to SIGN_EXTEND.
- Reset asserted mid-run: immediate return to reset values; M_TVALID drops asynchronously.

Test Plan:
1. SKIP=2, DEC=0, COUNT=4, READY=1, six strobes with ch1 values 1..6 -> beats carry ch1=3,4,5,6; TLAST on ch1=6; SAMPLES_WRITTEN=4; DONE pulses one cycle after the last handshake; OVERFLOW=0.
2. SKIP=0, DEC=2, COUNT=3, nine strobes with ch1 values 0..8 -> beats ch1=0,3,6; TLAST on ch1=6.
3. SIGN_EXTEND=1, ch1=14'h2000, ch2=14'h1FFF, ch3=0, ch4=14'h3FFF -> M_TDATA=64'hFFFF_0000_1FFF_E000.
4. COUNT=2, READY held 0, strobes on three consecutive cycles -> first beat held stable, strobes 2 and 3 dropped, OVERFLOW=1; READY=1, then two more strobes -> second beat with TLAST, DONE pulse.
5. COUNT=0 with START -> DONE one cycle later, no M_TVALID, BUSY high for exactly 1 cycle.
6. ABORT during CAPTURE with a stalled beat -> M_TVALID=0 next cycle, IDLE, no DONE; START in the same cycle as ABORT is ignored; the next START clears OVERFLOW and SAMPLES_WRITTEN.
